// File: rtl/fifo_ctrl_if.sv
// FIFO controller handshake bundle: push/pop requests in, storage strobes and status out.
// The master side issues requests; the slave side is the controller.
interface fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  // Requests towards the controller
  logic                  i_wr;
  logic                  i_rd;
  logic                  i_err_clr;

  // Storage array strobes and addresses
  logic                  o_w_en;
  logic [ADDR_WIDTH-1:0] o_w_addr;
  logic [ADDR_WIDTH-1:0] o_r_addr;

  // Occupancy status and sticky errors
  logic                  o_full;
  logic                  o_empty;
  logic                  o_almost_full;
  logic                  o_almost_empty;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_wr,
    output i_rd,
    output i_err_clr,
    input  o_w_en,
    input  o_w_addr,
    input  o_r_addr,
    input  o_full,
    input  o_empty,
    input  o_almost_full,
    input  o_almost_empty,
    input  o_count,
    input  o_overflow,
    input  o_underflow
  );

  modport slave (
    input  i_wr,
    input  i_rd,
    input  i_err_clr,
    output o_w_en,
    output o_w_addr,
    output o_r_addr,
    output o_full,
    output o_empty,
    output o_almost_full,
    output o_almost_empty,
    output o_count,
    output o_overflow,
    output o_underflow
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer-based FIFO controller for an external storage array with combinational read.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
// All status outputs come from registered pointers/flags; only o_w_en depends on requests.
// The interface instance must be built with the same ADDR_WIDTH as this module.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_LVL  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  fifo_ctrl_if.slave bus_io
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [PtrW-1:0] AfullLvl  = PtrW'(AFULL_LVL);
  localparam logic [PtrW-1:0] AemptyLvl = PtrW'(AEMPTY_LVL);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [PtrW-1:0] count;
  logic            full;
  logic            empty;
  logic            wr_accept;
  logic            rd_accept;
  logic            wr_reject;
  logic            rd_reject;

  // Occupancy status derived purely from the registered pointers
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
            (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  end

  // Request qualification; a pop frees the slot a full-FIFO push needs, but an empty
  // FIFO never reads through a same-cycle push
  always_comb begin
    rd_accept = bus_io.i_rd && !empty;
    wr_accept = bus_io.i_wr && (!full || bus_io.i_rd);
    wr_reject = bus_io.i_wr && !wr_accept;
    rd_reject = bus_io.i_rd && !rd_accept;
  end

  // Next-state: pointer advance and sticky error flags (a new error beats the clear)
  always_comb begin
    wr_ptr_d    = wr_accept ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d    = rd_accept ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    overflow_d  = wr_reject || (overflow_q && !bus_io.i_err_clr);
    underflow_d = rd_reject || (underflow_q && !bus_io.i_err_clr);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output drive; the write strobe is suppressed during reset so the array stays untouched
  always_comb begin
    bus_io.o_w_en         = wr_accept && !i_rst;
    bus_io.o_w_addr       = wr_ptr_q[ADDR_WIDTH-1:0];
    bus_io.o_r_addr       = rd_ptr_q[ADDR_WIDTH-1:0];
    bus_io.o_full         = full;
    bus_io.o_empty        = empty;
    bus_io.o_almost_full  = (count >= AfullLvl);
    bus_io.o_almost_empty = (count <= AemptyLvl);
    bus_io.o_count        = count;
    bus_io.o_overflow     = overflow_q;
    bus_io.o_underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: hand-derived vector table, directed corner
// sequences and randomized traffic compared against an occupancy/queue model.
module tb_fifo_ctrl;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          AFULL = DEPTH - 2;
  localparam int          AEMPTY = 2;

  logic clk;
  logic rst;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: totals of accepted pushes/pops, sticky flags, token queue
  int wr_total = 0;
  int rd_total = 0;
  bit m_ovf    = 1'b0;
  bit m_unf    = 1'b0;
  int q[$];
  int mem[DEPTH];
  int token    = 1;
  bit model_on = 1'b0;

  typedef struct {
    bit rst;
    bit wr;
    bit rd;
    bit clr;
    int count;
    bit empty;
    bit wen;
    bit unf;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, compare just after, advance the model
  task automatic cycle(input bit r, input bit w, input bit rd_i, input bit c);
    int  cnt;
    bit  wr_ok;
    bit  rd_ok;
    @(negedge clk);
    rst           = r;
    bus.i_wr      = w;
    bus.i_rd      = rd_i;
    bus.i_err_clr = c;
    #1;
    cnt   = wr_total - rd_total;
    wr_ok = !r && w && (cnt < DEPTH || rd_i);
    rd_ok = !r && rd_i && (cnt > 0);
    if (model_on) begin
      chk("count",    int'(bus.o_count),        cnt);
      chk("full",     int'(bus.o_full),         int'(cnt == DEPTH));
      chk("empty",    int'(bus.o_empty),        int'(cnt == 0));
      chk("afull",    int'(bus.o_almost_full),  int'(cnt >= AFULL));
      chk("aempty",   int'(bus.o_almost_empty), int'(cnt <= AEMPTY));
      chk("w_addr",   int'(bus.o_w_addr),       wr_total % DEPTH);
      chk("r_addr",   int'(bus.o_r_addr),       rd_total % DEPTH);
      chk("w_en",     int'(bus.o_w_en),         int'(wr_ok));
      chk("overflow", int'(bus.o_overflow),     int'(m_ovf));
      chk("underflow", int'(bus.o_underflow),   int'(m_unf));
    end
    // Storage array modelled from the DUT's strobes: read old data before any same-slot write
    if (rd_ok) begin
      if (q.size() == 0) chk("order_nonempty", 0, 1);
      else begin
        chk("order", mem[int'(bus.o_r_addr)], q[0]);
        void'(q.pop_front());
      end
    end
    if (bus.o_w_en) mem[int'(bus.o_w_addr)] = token;
    if (wr_ok) q.push_back(token);
    token++;
    if (r) begin
      wr_total = 0;
      rd_total = 0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      q.delete();
    end else begin
      if (wr_ok) wr_total++;
      if (rd_ok) rd_total++;
      m_ovf = (w && !wr_ok) || (m_ovf && !c);
      m_unf = (rd_i && !rd_ok) || (m_unf && !c);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_wr      = 1'b0;
    bus.i_rd      = 1'b0;
    bus.i_err_clr = 1'b0;

    // Reset from unknown state, then the model takes over
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    model_on = 1'b1;
    cycle(0, 0, 0, 0);
    chk("rst.empty",  int'(bus.o_empty), 1);
    chk("rst.aempty", int'(bus.o_almost_empty), 1);
    chk("rst.count",  int'(bus.o_count), 0);

    // Vector table: outputs seen during each row, before its clock edge
    vt[0]  = '{0, 1, 1, 0, 0, 1, 1, 0};  // empty push+pop: push only
    vt[1]  = '{0, 0, 0, 0, 1, 0, 0, 1};  // underflow now set
    vt[2]  = '{0, 0, 0, 1, 1, 0, 0, 1};  // clear pulse
    vt[3]  = '{0, 0, 1, 0, 1, 0, 0, 0};  // pop last entry
    vt[4]  = '{0, 0, 1, 0, 0, 1, 0, 0};  // pop when empty
    vt[5]  = '{0, 0, 0, 0, 0, 1, 0, 1};
    vt[6]  = '{0, 1, 0, 1, 0, 1, 1, 1};  // push with clear
    vt[7]  = '{0, 1, 1, 0, 1, 0, 1, 0};  // push+pop, count holds
    vt[8]  = '{1, 1, 0, 0, 1, 0, 0, 0};  // reset masks the write strobe
    vt[9]  = '{0, 0, 1, 1, 0, 1, 0, 0};  // error and clear together
    vt[10] = '{0, 0, 0, 0, 0, 1, 0, 1};  // error won
    vt[11] = '{0, 0, 0, 1, 0, 1, 0, 1};
    vt[12] = '{0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].rst, vt[i].wr, vt[i].rd, vt[i].clr);
      chk($sformatf("vec%0d.count", i), int'(bus.o_count), vt[i].count);
      chk($sformatf("vec%0d.empty", i), int'(bus.o_empty), int'(vt[i].empty));
      chk($sformatf("vec%0d.w_en", i),  int'(bus.o_w_en), int'(vt[i].wen));
      chk($sformatf("vec%0d.unf", i),   int'(bus.o_underflow), int'(vt[i].unf));
    end

    // Fill from reset: addresses 0..15 and threshold crossings
    cycle(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0, 0);
      chk("fill.w_addr", int'(bus.o_w_addr), i);
      chk("fill.afull",  int'(bus.o_almost_full), int'(i >= 14));
      chk("fill.aempty", int'(bus.o_almost_empty), int'(i <= 2));
    end
    cycle(0, 0, 0, 0);
    chk("fill.count", int'(bus.o_count), 16);
    chk("fill.full",  int'(bus.o_full), 1);

    // Push into a full FIFO is dropped and flagged
    cycle(0, 1, 0, 0);
    chk("ovf.w_en", int'(bus.o_w_en), 0);
    cycle(0, 0, 0, 0);
    chk("ovf.flag",  int'(bus.o_overflow), 1);
    chk("ovf.count", int'(bus.o_count), 16);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("ovf.cleared", int'(bus.o_overflow), 0);

    // Full-rate streaming while full, wrapping both addresses
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 0);
      chk("stream.w_en", int'(bus.o_w_en), 1);
      chk("stream.full", int'(bus.o_full), 1);
    end
    cycle(0, 0, 0, 0);
    chk("stream.ovf", int'(bus.o_overflow), 0);
    chk("stream.unf", int'(bus.o_underflow), 0);
    chk("stream.w_addr", int'(bus.o_w_addr), 4);

    // Empty with push+pop: push accepted, pop rejected
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    chk("nort.count",  int'(bus.o_count), 1);
    chk("nort.r_addr", int'(bus.o_r_addr), 0);
    chk("nort.unf",    int'(bus.o_underflow), 1);

    // Reset mid-operation with a pending push
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("midrst.w_en", int'(bus.o_w_en), 0);
    cycle(0, 0, 0, 0);
    chk("midrst.count", int'(bus.o_count), 0);
    chk("midrst.empty", int'(bus.o_empty), 1);
    chk("midrst.unf",   int'(bus.o_underflow), 0);
    chk("midrst.ovf",   int'(bus.o_overflow), 0);

    // Randomized traffic in phases biased towards filling, balance and draining
    for (int p = 0; p < 6; p++) begin
      int wp;
      int rp;
      wp = (p % 3 == 0) ? 80 : ((p % 3 == 1) ? 50 : 20);
      rp = 100 - wp;
      for (int i = 0; i < 60; i++) begin
        cycle(bit'($urandom_range(0, 199) == 0),
              bit'($urandom_range(0, 99) < wp),
              bit'($urandom_range(0, 99) < rp),
              bit'($urandom_range(0, 99) < 10));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
